// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame/oversampling
// constants reused by the baud generator, transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_TX_IDLE  = 2'd0,
        UART_TX_START = 2'd1,
        UART_TX_DATA  = 2'd2,
        UART_TX_STOP  = 2'd3
    } uart_tx_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_NUM_TICKS = 16;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping
// modulo NUM_REQ. Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx,
    output logic               grant_valid
);

    localparam int SW = IW + 1;
    localparam logic [SW-1:0] NUM_REQ_W = SW'(NUM_REQ);

    // Requests rotated so that position 0 is the current priority holder.
    logic [NUM_REQ-1:0] rot_req;
    logic [IW-1:0]      rot_idx [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        localparam logic [SW-1:0] OFFSET = SW'(gi);
        logic [SW-1:0] sum;
        assign sum          = {1'b0, ptr} + OFFSET;
        assign rot_idx[gi]  = (sum >= NUM_REQ_W) ? IW'(sum - NUM_REQ_W) : sum[IW-1:0];
        assign rot_req[gi]  = req[rot_idx[gi]];
    end

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && rot_req[k]) begin
                grant_valid = 1'b1;
                grant_idx   = rot_idx[k];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shares one UART TX line between NUM_REQ byte producers and serializes
// each accepted byte as an 8N1 frame paced by the oversampling tick.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int DATA_BITS = UART_DATA_BITS,
    parameter  int num_ticks = UART_NUM_TICKS,
    localparam int IW        = idx_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [IW-1:0]                 grant_id
);

    localparam int TW = idx_width(num_ticks);
    localparam int BW = idx_width(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(num_ticks - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [IW-1:0] REQ_LAST  = IW'(NUM_REQ - 1);

    uart_tx_state_e       state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic [IW-1:0]        grant_id_q, grant_id_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic                 bit_end;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_valid;
    logic [DATA_BITS-1:0] req_bytes [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
    end

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        req_ready  = '0;
        bit_end    = 1'b0;

        // The tick counter only runs inside a frame, so a tick landing on the
        // acceptance cycle never shortens the start bit.
        if (state_q != UART_TX_IDLE && tick) begin
            if (tick_cnt_q == TICK_LAST) begin
                tick_cnt_d = '0;
                bit_end    = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end

        case (state_q)
            UART_TX_IDLE: begin
                req_ready = arb_grant;
                if (arb_valid) begin
                    shreg_d    = req_bytes[arb_idx];
                    grant_id_d = arb_idx;
                    ptr_d      = (arb_idx == REQ_LAST) ? '0 : arb_idx + IW'(1);
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = UART_TX_START;
                end
            end
            UART_TX_START: begin
                if (bit_end) begin
                    tx_d      = shreg_q[0];
                    bit_cnt_d = '0;
                    state_d   = UART_TX_DATA;
                end
            end
            UART_TX_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                        state_d   = UART_TX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = shreg_d[0];
                    end
                end
            end
            UART_TX_STOP: begin
                if (bit_end) begin
                    busy_d  = 1'b0;
                    state_d = UART_TX_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = UART_TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= UART_TX_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter (three requesters); frames are
// checked against bit levels derived from elapsed tick counts and a round-robin model.
module tb_uart_tx_arbiter;

    localparam int NR = 3;
    localparam int DB = 8;
    localparam int NT = 16;
    localparam int FRAME_TICKS = (DB + 2) * NT;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            tick;
    logic            tick_gen = 1'b0;
    logic            tick_force = 1'b0;
    logic [NR-1:0]   req_valid = '0;
    logic [NR*DB-1:0] req_data = '0;
    logic [NR-1:0]   req_ready;
    logic            tx;
    logic            busy;
    logic [1:0]      grant_id;

    int total = 0;
    int bad = 0;
    int tick_total = 0;
    int t0 = 0;
    int tick_per = 4;
    bit tick_en = 1'b1;
    int div = 0;

    assign tick = tick_gen | tick_force;

    uart_tx_arbiter #(
        .NUM_REQ   (NR),
        .DATA_BITS (DB),
        .num_ticks (NT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_en && div >= tick_per - 1) begin
            tick_gen = 1'b1;
            div = 0;
        end else begin
            tick_gen = 1'b0;
            if (tick_en) div++;
        end
    end

    always @(posedge clk) begin
        if (tick) tick_total <= tick_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line level for bit-period index idx of an 8N1 frame carrying b.
    function automatic logic exp_level(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= DB + 1) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic accept(input string tag, input logic [NR-1:0] exp_ready,
                          input int exp_id, input bit force_tick);
        int waited;
        waited = 0;
        #1;
        while (req_ready === '0 && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check({tag, " ready"}, 32'(req_ready), 32'(exp_ready));
        if (force_tick) tick_force = 1'b1;
        @(negedge clk);
        #1;
        tick_force = 1'b0;
        t0 = tick_total;
        check({tag, " ready pulse"}, 32'(req_ready), 32'd0);
        check({tag, " start tx"}, 32'(tx), 32'd0);
        check({tag, " start busy"}, 32'(busy), 32'd1);
        check({tag, " grant_id"}, 32'(grant_id), 32'(exp_id));
    endtask

    // Walk the frame until to_e ticks after START entry, checking tx and busy.
    task automatic frame_seg(input string tag, input logic [7:0] b, input int to_e);
        int e;
        int errs;
        int cyc;
        errs = 0;
        cyc = 0;
        e = tick_total - t0;
        while (e < to_e && cyc < 4000) begin
            if (tx !== exp_level(b, e / NT) || busy !== 1'b1) errs++;
            @(negedge clk);
            cyc++;
            e = tick_total - t0;
        end
        check({tag, " bit errors"}, 32'(errs), 32'd0);
        check({tag, " reached tick"}, 32'(e), 32'(to_e));
        if (to_e == FRAME_TICKS) begin
            check({tag, " idle busy"}, 32'(busy), 32'd0);
            check({tag, " idle tx"}, 32'(tx), 32'd1);
        end
    endtask

    initial begin
        int errs;
        int e_hold;
        int mptr;
        int id;
        logic [NR-1:0] mask;
        logic [7:0] bytes [NR];

        // 1: reset state and quiet line
        do_reset();
        check("rst tx", 32'(tx), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst ready", 32'(req_ready), 32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        errs = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || req_ready !== '0 || busy !== 1'b0) errs++;
        end
        check("idle 1000 clk", 32'(errs), 32'd0);

        // 2: single byte from requester 0
        req_data[0*DB +: DB] = 8'hA5;
        req_valid = 3'b001;
        accept("t2", 3'b001, 0, 1'b0);
        req_valid = '0;
        frame_seg("t2 A5", 8'hA5, FRAME_TICKS);

        // 3: two requesters holding valid alternate
        do_reset();
        req_data[0*DB +: DB] = 8'h55;
        req_data[1*DB +: DB] = 8'h0F;
        req_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            accept($sformatf("t3 f%0d", k), onehot(k % 2), k % 2, 1'b0);
            frame_seg($sformatf("t3 f%0d", k), (k % 2 == 0) ? 8'h55 : 8'h0F, FRAME_TICKS);
        end
        req_valid = '0;

        // 4: reset during data bit 3, held request re-accepted
        do_reset();
        req_data[0*DB +: DB] = 8'h3C;
        req_valid = 3'b001;
        accept("t4 first", 3'b001, 0, 1'b0);
        frame_seg("t4 partial", 8'h3C, 4 * NT + 8);
        reset = 1'b1;
        @(negedge clk);
        check("t4 reset tx", 32'(tx), 32'd1);
        check("t4 reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        accept("t4 again", 3'b001, 0, 1'b0);
        frame_seg("t4 3C", 8'h3C, FRAME_TICKS);
        req_valid = '0;

        // 5: tick on the acceptance cycle, then a long tick stall
        tick_en = 1'b0;
        repeat (3) @(negedge clk);
        req_data[0*DB +: DB] = 8'hC3;
        req_valid = 3'b001;
        accept("t5", 3'b001, 0, 1'b1);
        req_valid = '0;
        tick_en = 1'b1;
        frame_seg("t5 pre", 8'hC3, 40);
        tick_en = 1'b0;
        @(negedge clk);
        e_hold = tick_total - t0;
        errs = 0;
        repeat (500) begin
            @(negedge clk);
            if (tx !== exp_level(8'hC3, e_hold / NT) || (tick_total - t0) != e_hold) errs++;
        end
        check("t5 stall", 32'(errs), 32'd0);
        tick_en = 1'b1;
        frame_seg("t5 C3", 8'hC3, FRAME_TICKS);

        // 6: only requester 2, then priority wraps back to 0
        do_reset();
        req_data[2*DB +: DB] = 8'h81;
        req_valid = 3'b100;
        accept("t6", 3'b100, 2, 1'b0);
        req_valid = '0;
        frame_seg("t6 81", 8'h81, FRAME_TICKS);
        req_data = {8'h33, 8'h22, 8'h11};
        req_valid = 3'b111;
        accept("t6 wrap", 3'b001, 0, 1'b0);
        frame_seg("t6 11", 8'h11, FRAME_TICKS);
        mptr = 1;

        // Randomized rounds checked against a round-robin model
        for (int r = 0; r < 12; r++) begin
            tick_per = $urandom_range(1, 6);
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                bytes[i] = 8'($urandom_range(0, 255));
                req_data[i*DB +: DB] = bytes[i];
            end
            req_valid = mask;
            id = -1;
            for (int k = 0; k < NR; k++) begin
                if (id < 0 && mask[(mptr + k) % NR]) id = (mptr + k) % NR;
            end
            accept($sformatf("rnd%0d", r), onehot(id), id, 1'b0);
            frame_seg($sformatf("rnd%0d", r), bytes[id], FRAME_TICKS);
            mptr = (id + 1) % NR;
        end
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
